point_spawn_ctrl: RTL

- Sequences food-point placement for the two-player snake game.
- Arbitrates "ate point" events from the local and remote snakes and steps a pair of 5-bit LFSRs to produce candidate cells.
- Queries the board occupancy RAM for each candidate and retries until it finds a free cell.
- Publishes the committed point to the renderer and collision logic.

---
 rtl/point_spawn_ctrl_if.sv | 22 ++
 rtl/point_spawn_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/point_spawn_ctrl_if.sv
// Occupancy RAM read port shared between the spawn controller and the board RAM.
// Read data returns one cycle after the strobe.
interface point_spawn_ctrl_if;
  logic       occ_rd_en;
  logic [4:0] occ_rd_x;
  logic [4:0] occ_rd_y;
  logic       occ_rd_data;

  modport master (
    output occ_rd_en,
    output occ_rd_x,
    output occ_rd_y,
    input  occ_rd_data
  );

  modport slave (
    input  occ_rd_en,
    input  occ_rd_x,
    input  occ_rd_y,
    output occ_rd_data
  );
endinterface

// File: rtl/point_spawn_ctrl.sv
// Food-point spawn sequencer: arbitrates eat events, steps two 5-bit LFSRs and
// retries candidates against the occupancy RAM until a free cell is committed.
module point_spawn_ctrl #(
  parameter int X_RANGE   = 30,
  parameter int Y_RANGE   = 22,
  parameter int MAX_TRIES = 8
) (
  input  logic                     clk_75,
  input  logic                     rst,
  input  logic                     game_active,
  input  logic                     seed_load,
  input  logic [4:0]               seed_x,
  input  logic [4:0]               seed_y,
  input  logic                     eat_local,
  input  logic                     eat_remote,
  point_spawn_ctrl_if.master       occ,
  output logic [4:0]               point_x,
  output logic [4:0]               point_y,
  output logic                     point_valid,
  output logic                     point_update,
  output logic                     grant_local,
  output logic                     grant_remote,
  output logic                     busy,
  output logic                     spawn_fail
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    QUERY,
    CHECK,
    COMMIT
  } state_t;

  state_t               state_q, state_d;
  logic   [4:0]         lfsr_x_q, lfsr_x_d;
  logic   [4:0]         lfsr_y_q, lfsr_y_d;
  logic   [4:0]         cx_q, cx_d;
  logic   [4:0]         cy_q, cy_d;
  logic   [TRIES_W-1:0] tries_q, tries_d;
  logic                 rr_q, rr_d;
  logic   [4:0]         point_x_q, point_x_d;
  logic   [4:0]         point_y_q, point_y_d;
  logic                 point_valid_q, point_valid_d;
  logic                 grant_l_q, grant_l_d;
  logic                 grant_r_q, grant_r_d;

  function automatic logic [4:0] lfsr_step(input logic [4:0] v);
    return {v[3], v[2], v[1], v[0] ^ v[4], v[4]};
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
  function automatic logic [4:0] seed_fix(input logic [4:0] s);
    return (s == 5'd0) ? 5'd1 : s;
  endfunction

  function automatic logic [4:0] to_coord(input logic [4:0] v, input logic [4:0] range);
    return (v % range) + 5'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    lfsr_x_d      = lfsr_x_q;
    lfsr_y_d      = lfsr_y_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    tries_d       = tries_q;
    rr_d          = rr_q;
    point_x_d     = point_x_q;
    point_y_d     = point_y_q;
    point_valid_d = point_valid_q;
    grant_l_d     = 1'b0;
    grant_r_d     = 1'b0;
    spawn_fail    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_x_d      = seed_fix(seed_x);
          lfsr_y_d      = seed_fix(seed_y);
          point_valid_d = 1'b0;
          tries_d       = '0;
          state_d       = STEP;
        end else if (point_valid_q && (eat_local || eat_remote)) begin
          point_valid_d = 1'b0;
          state_d       = STEP;
          // rr_q = 0 favours the local snake on a tie; the loser is dropped.
          if (eat_local && eat_remote) begin
            grant_l_d = ~rr_q;
            grant_r_d = rr_q;
            rr_d      = ~rr_q;
          end else begin
            grant_l_d = eat_local;
            grant_r_d = eat_remote;
          end
        end
      end
      STEP: begin
        lfsr_x_d = lfsr_step(lfsr_x_q);
        lfsr_y_d = lfsr_step(lfsr_y_q);
        cx_d     = to_coord(lfsr_x_d, 5'(X_RANGE));
        cy_d     = to_coord(lfsr_y_d, 5'(Y_RANGE));
        state_d  = QUERY;
      end
      QUERY: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (occ.occ_rd_data) begin
          state_d = STEP;
          if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
            spawn_fail = 1'b1;
            tries_d    = '0;
          end else begin
            tries_d = tries_q + TRIES_W'(1);
          end
        end else begin
          // Point registers load here so they are already valid during COMMIT.
          point_x_d     = cx_q;
          point_y_d     = cy_q;
          point_valid_d = 1'b1;
          state_d       = COMMIT;
        end
      end
      COMMIT: begin
        tries_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving the game freezes the LFSRs and the last point but drops validity.
    if (!game_active) begin
      state_d       = IDLE;
      lfsr_x_d      = lfsr_x_q;
      lfsr_y_d      = lfsr_y_q;
      tries_d       = '0;
      rr_d          = rr_q;
      point_x_d     = point_x_q;
      point_y_d     = point_y_q;
      point_valid_d = 1'b0;
      grant_l_d     = 1'b0;
      grant_r_d     = 1'b0;
      spawn_fail    = 1'b0;
    end
  end

  always_ff @(posedge clk_75) begin
    if (rst) begin
      state_q       <= IDLE;
      lfsr_x_q      <= 5'd1;
      lfsr_y_q      <= 5'd1;
      tries_q       <= '0;
      rr_q          <= 1'b0;
      point_x_q     <= 5'd0;
      point_y_q     <= 5'd0;
      point_valid_q <= 1'b0;
      grant_l_q     <= 1'b0;
      grant_r_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_x_q      <= lfsr_x_d;
      lfsr_y_q      <= lfsr_y_d;
      tries_q       <= tries_d;
      rr_q          <= rr_d;
      point_x_q     <= point_x_d;
      point_y_q     <= point_y_d;
      point_valid_q <= point_valid_d;
      grant_l_q     <= grant_l_d;
      grant_r_q     <= grant_r_d;
    end
  end

  // Candidate cell is pure data and is only observed in QUERY/CHECK.
  always_ff @(posedge clk_75) begin
    cx_q <= cx_d;
    cy_q <= cy_d;
  end

  assign occ.occ_rd_en = (state_q == QUERY);
  assign occ.occ_rd_x  = (state_q == QUERY) ? cx_q : 5'd0;
  assign occ.occ_rd_y  = (state_q == QUERY) ? cy_q : 5'd0;

  assign point_x      = point_x_q;
  assign point_y      = point_y_q;
  assign point_valid  = point_valid_q;
  assign point_update = (state_q == COMMIT);
  assign grant_local  = grant_l_q;
  assign grant_remote = grant_r_q;
  assign busy         = (state_q != IDLE);

endmodule
